mem_write_monitor: RTL

Synthesizable self-check monitor that sits on the single-cycle CPU's data-memory write port (`memwrite`, `dataaddr`, `writedata`) and decides pass/fail for a program run. It generalises the fixed "address 88 / data 30" check with parameterised pass criteria, an allowed address window, an alignment check and a watchdog timeout. It keeps a ring buffer of recent writes for post-mortem inspection. It is used in the CPU bench and can also be instantiated on FPGA builds to drive status LEDs.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/write_trace_buf.sv | 53 +++++
 rtl/mem_write_monitor.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the CPU bench and its data-memory write monitor.
package cpu_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } mon_state_t;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_BAD_ADDR = 3'd1,
    FC_BAD_DATA = 3'd2,
    FC_MISALIGN = 3'd3,
    FC_TIMEOUT  = 3'd4
  } fail_code_t;

endpackage

// File: rtl/write_trace_buf.sv
// Ring buffer of recent stores, read back relative to the newest entry
// (index 0 is the most recent push).
module write_trace_buf
  import cpu_pkg::*;
#(
  parameter int TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push_i,
  input  u32                             addr_i,
  input  u32                             data_i,
  input  logic [$clog2(TRACE_DEPTH)-1:0] idx_i,
  output u32                             addr_o,
  output u32                             data_o,
  output u1                              valid_o
);

  localparam int IW = $clog2(TRACE_DEPTH);

  u32             addr_mem_q [TRACE_DEPTH];
  u32             data_mem_q [TRACE_DEPTH];
  logic [IW-1:0]  wr_ptr_q;
  logic [IW:0]    occ_q;
  logic [IW-1:0]  rd_ptr;

  // Occupancy saturates at the depth so it doubles as the valid bound.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else if (push_i) begin
      wr_ptr_q <= wr_ptr_q + IW'(1);
      if (occ_q != (IW+1)'(TRACE_DEPTH)) begin
        occ_q <= occ_q + (IW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_mem_q[wr_ptr_q] <= addr_i;
      data_mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Power-of-two depth lets the pointer arithmetic wrap for free.
  assign rd_ptr  = wr_ptr_q - IW'(1) - idx_i;
  assign valid_o = ({1'b0, idx_i} < occ_q);
  assign addr_o  = valid_o ? addr_mem_q[rd_ptr] : '0;
  assign data_o  = valid_o ? data_mem_q[rd_ptr] : '0;

endmodule

// File: rtl/mem_write_monitor.sv
// Pass/fail monitor on the CPU data-memory write port with address window,
// alignment, terminal-write and watchdog checks plus a trace of recent stores.
module mem_write_monitor
  import cpu_pkg::*;
#(
  parameter u32          PASS_ADDR    = 32'd88,
  parameter u32          PASS_DATA    = 32'd30,
  parameter u32          ALLOW_LO     = 32'd80,
  parameter u32          ALLOW_HI     = 32'd84,
  parameter bit          STRICT_ALIGN = 1'b1,
  parameter int unsigned TIMEOUT      = 1000,
  parameter int          TRACE_DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           memwrite,
  input  logic [31:0]                    dataaddr,
  input  logic [31:0]                    writedata,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic                           done,
  output logic                           pass,
  output logic [2:0]                     fail_code,
  output logic [15:0]                    write_count,
  output logic [31:0]                    cycle_count,
  output logic [31:0]                    trace_addr,
  output logic [31:0]                    trace_data,
  output logic                           trace_valid
);

  mon_state_t  state_q, state_d;
  fail_code_t  code_q, code_d;
  logic [15:0] wc_q, wc_d;
  u32          cc_q, cc_d;
  u1           trace_push;
  u1           write_decided;
  u1           hit_pass_addr;
  u1           misaligned;
  u1           out_of_window;
  u1           wd_expire;

  assign hit_pass_addr = (dataaddr == PASS_ADDR);
  assign misaligned    = STRICT_ALIGN && (dataaddr[1:0] != 2'b00);
  assign out_of_window = (dataaddr < ALLOW_LO) || (dataaddr > ALLOW_HI);
  assign wd_expire     = (TIMEOUT != 0) && (cc_q == u32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      code_q  <= FC_NONE;
      wc_q    <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      wc_q    <= wc_d;
      cc_q    <= cc_d;
    end
  end

  // A store's verdict outranks the watchdog expiring on the same edge.
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    wc_d          = wc_q;
    cc_d          = cc_q;
    trace_push    = 1'b0;
    write_decided = 1'b0;
    if (state_q == ST_RUN) begin
      if (cc_q != '1) cc_d = cc_q + 32'd1;
      if (memwrite) begin
        trace_push    = 1'b1;
        write_decided = 1'b1;
        if (wc_q != '1) wc_d = wc_q + 16'd1;
        if (hit_pass_addr && (writedata == PASS_DATA)) begin
          state_d = ST_PASS;
        end else if (misaligned) begin
          state_d = ST_FAIL;
          code_d  = FC_MISALIGN;
        end else if (hit_pass_addr) begin
          state_d = ST_FAIL;
          code_d  = FC_BAD_DATA;
        end else if (out_of_window) begin
          state_d = ST_FAIL;
          code_d  = FC_BAD_ADDR;
        end else begin
          write_decided = 1'b0;
        end
      end
      if (!write_decided && wd_expire) begin
        state_d = ST_FAIL;
        code_d  = FC_TIMEOUT;
      end
    end
  end

  assign done        = (state_q != ST_RUN);
  assign pass        = (state_q == ST_PASS);
  assign fail_code   = code_q;
  assign write_count = wc_q;
  assign cycle_count = cc_q;

  write_trace_buf #(
    .TRACE_DEPTH(TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .reset   (reset),
    .push_i  (trace_push),
    .addr_i  (dataaddr),
    .data_i  (writedata),
    .idx_i   (trace_idx),
    .addr_o  (trace_addr),
    .data_o  (trace_data),
    .valid_o (trace_valid)
  );

endmodule
